// File: rtl/multiword_add_pkg.sv
// Shared types and defaults for the multi-precision adder sequencer.
// Holds the FSM state encoding and the default slice geometry.
package multiword_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int N_DEF     = 16;
    localparam int WORDS_DEF = 4;

endpackage

// File: rtl/multiword_add_sequencer_adder.sv
// N-bit ripple-carry full adder used as the single shared slice datapath.
// Carry is propagated bit by bit through a local variable.
module RippleFullAdder #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    always_comb begin
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-precision add sequencer: one N-bit adder reused over WORDS cycles.
// Define MULTIWORD_ADD_SUB_EN to add the sub port (A - B via inverted B).
module multiword_add_sequencer
    import multiword_add_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int WORDS = WORDS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] op_a,
    input  logic [N*WORDS-1:0] op_b,
    input  logic               cin,
`ifdef MULTIWORD_ADD_SUB_EN
    input  logic               sub,
`endif
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*WORDS-1:0] result,
    output logic               cout,
    output logic               busy
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic          carry;
    logic [W-1:0]  a_r, b_r;
    logic          inv_b;
    logic [N-1:0]  sa, sb, ss;
    logic          co;
    logic          last;
    logic          accept;

`ifdef MULTIWORD_ADD_SUB_EN
    logic sub_r;
    assign inv_b = sub_r;
`else
    assign inv_b = 1'b0;
`endif

    assign accept      = (state == IDLE) && start_valid;
    assign last        = (idx == IW'(WORDS - 1));
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

    assign sa = a_r[idx*N +: N];
    assign sb = b_r[idx*N +: N] ^ {N{inv_b}};

    RippleFullAdder #(.N(N)) u_adder (
        .a  (sa),
        .b  (sb),
        .ci (carry),
        .s  (ss),
        .co (co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start_valid) state_nx = RUN;
            RUN:     if (last)        state_nx = DONE;
            DONE:    if (res_ready)   state_nx = IDLE;
            default:                  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            idx    <= '0;
            carry  <= 1'b0;
            result <= '0;
            cout   <= 1'b0;
`ifdef MULTIWORD_ADD_SUB_EN
            sub_r  <= 1'b0;
`endif
        end else if (accept) begin
            a_r   <= op_a;
            b_r   <= op_b;
            idx   <= '0;
`ifdef MULTIWORD_ADD_SUB_EN
            sub_r <= sub;
            carry <= sub | cin;
`else
            carry <= cin;
`endif
        end else if (state == RUN) begin
            result[idx*N +: N] <= ss;
            carry              <= co;
            if (last) begin
                // Wrap so idx is already 0 for the next request
                idx  <= '0;
                cout <= co;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer (16x4 and 8x1 instances).
// Vector table plus hand sequences for backpressure, reset and sub.
module tb_multiword_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid, start_ready;
    logic [63:0] op_a, op_b;
    logic        cin, sub;
    logic        res_valid, res_ready;
    logic [63:0] result;
    logic        cout, busy;

    logic       d_start_valid, d_start_ready;
    logic [7:0] d_op_a, d_op_b, d_result;
    logic       d_res_valid, d_res_ready, d_cout, d_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    multiword_add_sequencer #(.N(16), .WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .cin         (cin),
`ifdef MULTIWORD_ADD_SUB_EN
        .sub         (sub),
`endif
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .cout        (cout),
        .busy        (busy)
    );

    multiword_add_sequencer #(.N(8), .WORDS(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .start_valid (d_start_valid),
        .start_ready (d_start_ready),
        .op_a        (d_op_a),
        .op_b        (d_op_b),
        .cin         (1'b0),
`ifdef MULTIWORD_ADD_SUB_EN
        .sub         (1'b0),
`endif
        .res_valid   (d_res_valid),
        .res_ready   (d_res_ready),
        .result      (d_result),
        .cout        (d_cout),
        .busy        (d_busy)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        ci;
        logic [63:0] res;
        logic        co;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic s);
        @(negedge clk);
        check("start_ready_before_send", {63'd0, start_ready}, 64'd1);
        start_valid = 1'b1;
        op_a = a;
        op_b = b;
        cin  = c;
        sub  = s;
        @(posedge clk);
        #1 start_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (res_valid) break;
        end
    endtask

    task automatic take();
        res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
        @(negedge clk);
        check("start_ready_after_take", {63'd0, start_ready}, 64'd1);
        check("res_valid_after_take", {63'd0, res_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        logic [63:0] held;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1};
        vecs[1] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
                    1'b0, 64'h0001_0000_0001_0000, 1'b0};
        vecs[2] = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0};
        vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                    1'b0, 64'h0, 1'b1};
        vecs[4] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
                    1'b0, 64'h2345_6789_ABCD_F001, 1'b0};
        vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

        rst = 1'b1;
        start_valid = 1'b0;
        res_ready = 1'b0;
        op_a = '0;
        op_b = '0;
        cin = 1'b0;
        sub = 1'b0;
        d_start_valid = 1'b0;
        d_res_ready = 1'b0;
        d_op_a = '0;
        d_op_b = '0;

        #12;
        check("rst_start_ready", {63'd0, start_ready}, 64'd1);
        check("rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0);
            wait_valid(lat);
            check($sformatf("lat_v%0d", i), 64'(lat), 64'd5);
            check($sformatf("res_v%0d", i), result, vecs[i].res);
            check($sformatf("cout_v%0d", i), {63'd0, cout},
                  {63'd0, vecs[i].co});
            check($sformatf("busy_v%0d", i), {63'd0, busy}, 64'd1);
            take();
        end

        // Backpressure with a stray start held through RUN and DONE
        send(64'd1, 64'd2, 1'b0, 1'b0);
        start_valid = 1'b1;
        op_a = 64'd100;
        op_b = 64'd200;
        wait_valid(lat);
        check("bp_lat", 64'(lat), 64'd5);
        held = result;
        check("bp_res", held, 64'd3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_res_stable", result, 64'd3);
            check("bp_cout_stable", {63'd0, cout}, 64'd0);
            check("bp_start_ready", {63'd0, start_ready}, 64'd0);
            check("bp_res_valid", {63'd0, res_valid}, 64'd1);
        end
        start_valid = 1'b0;
        take();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_stray_op", {62'd0, busy, res_valid}, 64'd0);
        end
        send(64'd10, 64'd20, 1'b0, 1'b0);
        wait_valid(lat);
        check("after_bp_res", result, 64'd30);
        take();

        // Reset while idx==2
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_start_ready", {63'd0, start_ready}, 64'd1);
        check("mid_rst_res_valid", {63'd0, res_valid}, 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_result", result, 64'd0);
        check("mid_rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        send(64'd1, 64'd1, 1'b0, 1'b0);
        wait_valid(lat);
        check("post_rst_lat", 64'(lat), 64'd5);
        check("post_rst_res", result, 64'd2);
        take();

        // Single-slice instance
        @(negedge clk);
        d_start_valid = 1'b1;
        d_op_a = 8'hFF;
        d_op_b = 8'h01;
        @(posedge clk);
        #1 d_start_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            lat++;
            if (d_res_valid) break;
        end
        check("w1_lat", 64'(lat), 64'd2);
        check("w1_res", {56'd0, d_result}, 64'd0);
        check("w1_cout", {63'd0, d_cout}, 64'd1);
        d_res_ready = 1'b1;
        @(posedge clk);
        #1 d_res_ready = 1'b0;
        @(negedge clk);
        check("w1_start_ready", {63'd0, d_start_ready}, 64'd1);

`ifdef MULTIWORD_ADD_SUB_EN
        send(64'd5, 64'd7, 1'b0, 1'b1);
        wait_valid(lat);
        check("sub_5_7_res", result, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_5_7_cout", {63'd0, cout}, 64'd0);
        take();
        send(64'd7, 64'd5, 1'b0, 1'b1);
        wait_valid(lat);
        check("sub_7_5_res", result, 64'd2);
        check("sub_7_5_cout", {63'd0, cout}, 64'd1);
        take();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multiword_add_sequencer.md
# multiword_add_sequencer

Multi-precision adder sequencer. It computes a WORDS×N-bit sum by time-multiplexing one N-bit ripple adder over WORDS consecutive cycles, chaining the carry through a register. It sits between a requester and the narrow adder datapath, so wide additions reuse a single N-bit carry chain instead of a WORDS×N-bit one. Requests arrive and results leave on valid/ready handshakes.

## Interface
- N, default 16: adder slice width in bits (≥1).
- WORDS, default 4: number of slices per operation (≥1); operand width W = N*WORDS.
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request present; op_a, op_b, cin (and sub) are valid.
- start_ready  output  1  block is in IDLE and can accept a request.
- op_a  input  W  operand A.
- op_b  input  W  operand B.
- cin  input  1  carry-in to slice 0.
- res_valid  output  1  result and cout are valid.
- res_ready  input  1  consumer accepts the result.
- result  output  W  sum.
- cout  output  1  carry-out of the top slice.
- busy  output  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. The reset state is IDLE.
- IDLE:
  - start_ready=1.
  - On start_valid&&start_ready, latch op_a, op_b, cin (and sub), clear idx to 0, and go to RUN.
- RUN, one slice per cycle:
  - Drive slice idx of A and B plus the carry register into the adder.
  - Write the sum into result[idx*N +: N] and the adder's carry-out into the carry register.
  - idx counts 0..WORDS-1, width $clog2(WORDS) with a minimum of 1.
  - When idx==WORDS-1, the final carry goes to cout and the FSM moves to DONE.
- DONE:
  - res_valid=1; result and cout are held stable.
  - On res_ready, go to IDLE.
- Arithmetic:
  - result = (A + B + cin) mod 2^W.
  - cout = bit W of the true sum.
- start_valid outside IDLE is ignored, because start_ready=0 there; inputs are not sampled.
- result is only updated in RUN. Outside RUN it holds its last value.
- WORDS=1: RUN lasts exactly one cycle.
- Asynchronous reset mid-operation aborts immediately:
  - State returns to IDLE.
  - idx, carry, result and cout are cleared to 0.
  - No partial result is presented.

## Timing
- Reset values: start_ready=1, res_valid=0, busy=0, result=0, cout=0.
- Request accepted at edge E0. RUN then occupies the cycles between edges E1..EWORDS.
- res_valid rises after edge EWORDS and is visible in cycle WORDS+1. Latency is WORDS+1 cycles from acceptance.
- Result handshake completes at the edge where res_valid&&res_ready. start_ready is 1 in the next cycle.
- Maximum throughput is one operation per WORDS+2 cycles.
- No combinational path from start_valid or res_ready to any output.

## Configuration
- The macro MULTIWORD_ADD_SUB_EN selects whether subtraction is supported.
- Defined:
  - An extra input port `sub` (1 bit) is added and latched with the request.
  - When sub=1, every B slice is inverted before the adder and the initial carry is forced to 1, so cin is ignored. result = A − B mod 2^W.
  - cout=1 means no borrow (A ≥ B).
- Undefined:
  - The `sub` port is absent and the block only adds.

## Structure
- Shared package multiword_add_pkg holds:
  - the FSM state typedef (IDLE/RUN/DONE, 2-bit enum);
  - the default N and WORDS constants.
- One sub-module: a single N-bit ripple full adder instance, RippleFullAdder with N passed through.
  - Its carry-in is driven from the carry register.
  - Its carry-out is captured into the carry register.
- No other hierarchy.

## Test plan
- Carry through all slices (N=16, WORDS=4): A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> result=0, cout=1, res_valid in cycle 5 after acceptance.
- Per-slice carry propagation: A=0x0000_FFFF_0000_FFFF, B=0x0000_0001_0000_0001, cin=0 -> result=0x0001_0000_0001_0000, cout=0.
- Backpressure and ignored start:
  - Hold res_ready=0 for 3 cycles -> result and cout stay stable, start_ready=0.
  - A start_valid pulse during RUN/DONE is not accepted.
  - The next accepted request produces the correct new sum.
- Reset mid-RUN:
  - Assert rst at idx=2 -> outputs return to their reset values in the same cycle.
  - After release, a fresh 1+1 request returns 2.
- Degenerate case: WORDS=1, N=8, A=0xFF, B=0x01 -> result=0x00, cout=1, latency 2 cycles.
- With MULTIWORD_ADD_SUB_EN, sub=1:
  - A=5, B=7 -> result=0xFFFF_FFFF_FFFF_FFFE, cout=0.
  - A=7, B=5 -> result=2, cout=1.
